// File: rtl/xrisc_mbox_pkg.sv
// Shared types and default constants for the data-memory mailbox.
// Holds FSM states, verdict encodings and default address map values.
package xrisc_mbox_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned DEF_DEPTH_WORDS    = 64;
  localparam int unsigned DEF_MAILBOX_ADDR   = 100;
  localparam int unsigned DEF_EXPECT_VALUE   = 25;
  localparam int unsigned DEF_SCRATCH_ADDR   = 96;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_BAD_VALUE = 2'd1,
    FC_ILLEGAL   = 2'd2,
    FC_TIMEOUT   = 2'd3
  } fail_code_e;

  // Word-aligned and inside the RAM byte range.
  function automatic logic addr_legal(input logic [WORD_W-1:0] adr,
                                      input int unsigned depth_words);
    return (adr[1:0] == 2'b00) && (adr < 32'(4 * depth_words));
  endfunction

endpackage

// File: rtl/xrisc_dmem_ram.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset.
module xrisc_dmem_ram
  import xrisc_mbox_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/xrisc_dmem_mailbox.sv
// Test-harness data memory: watches core stores for a mailbox verdict,
// flags illegal stores and times out a run that never reports.
module xrisc_dmem_mailbox
  import xrisc_mbox_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = DEF_DEPTH_WORDS,
  parameter int unsigned MAILBOX_ADDR   = DEF_MAILBOX_ADDR,
  parameter int unsigned EXPECT_VALUE   = DEF_EXPECT_VALUE,
  parameter int unsigned SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] DataAdr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  store_count
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state;
  logic [31:0]       cyc_cnt;
  logic              legal;
  logic              in_run;
  logic              store_ok;
  logic              store_bad;
  logic              mbox_hit;
  logic              value_ok;
  logic              timeout_hit;
  logic              ram_we;
  logic [AW-1:0]     word_idx;
  logic [WORD_W-1:0] ram_rdata;

  assign legal       = addr_legal(DataAdr, DEPTH_WORDS);
  assign in_run      = (state == ST_RUN);
  assign store_ok    = in_run && MemWrite && legal;
  assign store_bad   = in_run && MemWrite && !legal;
  // Scratch stores never produce a verdict, even if it aliases the mailbox.
  assign mbox_hit    = (DataAdr == 32'(MAILBOX_ADDR)) && (DataAdr != 32'(SCRATCH_ADDR));
  assign value_ok    = (WriteData == 32'(EXPECT_VALUE));
  assign timeout_hit = (cyc_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign ram_we      = store_ok && !reset;
  assign word_idx    = DataAdr[AW+1:2];
  assign ReadData    = legal ? ram_rdata : '0;

  xrisc_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (word_idx),
    .wdata(WriteData),
    .rdata(ram_rdata)
  );

  // Verdict FSM; store/mailbox verdicts outrank the timeout in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FC_NONE;
      store_count <= '0;
      cyc_cnt     <= '0;
    end else if (in_run) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (store_ok && (store_count != 16'hFFFF)) begin
        store_count <= store_count + 16'd1;
      end
      if (store_bad) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= FC_ILLEGAL;
      end else if (store_ok && mbox_hit) begin
        done <= 1'b1;
        if (value_ok) begin
          state <= ST_PASS;
          pass  <= 1'b1;
        end else begin
          state     <= ST_FAIL;
          fail_code <= FC_BAD_VALUE;
        end
      end else if (timeout_hit) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= FC_TIMEOUT;
      end
    end
  end

endmodule

// File: doc/xrisc_dmem_mailbox.md
XRISC_DMEM_MAILBOX -- requirements
Module: xrisc_dmem_mailbox

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 64, number of 32-bit data RAM words (power of two, byte range 0..4*DEPTH_WORDS-1).
REQ-002 SHALL have parameter MAILBOX_ADDR, 100, byte address whose store ends the test.
REQ-003 SHALL have parameter EXPECT_VALUE, 25, store value to MAILBOX_ADDR that signals pass.
REQ-004 SHALL have parameter SCRATCH_ADDR, 96, byte address where stores are always legal.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 1000, cycles in RUN before a timeout verdict.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port MemWrite  input  1  store strobe from core, sampled each rising edge.
REQ-009 SHALL have port DataAdr  input  32  byte address of load/store.
REQ-010 SHALL have port WriteData  input  32  store data.
REQ-011 SHALL have port ReadData  output  32  load data, combinational from DataAdr.
REQ-012 SHALL have port done  output  1  verdict reached (sticky).
REQ-013 SHALL have port pass  output  1  verdict is pass (sticky).
REQ-014 SHALL have port fail_code  output  2  0 none, 1 wrong mailbox value, 2 illegal store, 3 timeout.
REQ-015 SHALL have port store_count  output  16  accepted stores since reset.

Function
REQ-016 SHALL implement FSM states RUN, PASS, FAIL; RUN entered at reset.
REQ-017 SHALL accept a store in RUN when MemWrite=1, DataAdr[1:0]=0 and DataAdr < 4*DEPTH_WORDS; RAM word DataAdr[..:2] takes WriteData at that edge.
REQ-018 SHALL, on accepted store to MAILBOX_ADDR with WriteData==EXPECT_VALUE, go RUN->PASS; done=1, pass=1 from next cycle.
REQ-019 SHALL, on accepted store to MAILBOX_ADDR with other data, go RUN->FAIL with fail_code=1; RAM still updated.
REQ-020 SHALL, on any store in RUN that is misaligned or out of range, go RUN->FAIL with fail_code=2 and leave RAM unchanged.
REQ-021 SHALL treat stores to SCRATCH_ADDR as ordinary accepted stores with no verdict.
REQ-022 SHALL count cycles in RUN; counter reaching TIMEOUT_CYCLES-1 with no verdict that edge -> FAIL, fail_code=3.
REQ-023 SHALL give mailbox/illegal-store verdicts priority over timeout in the same cycle.
REQ-024 SHALL ignore all stores in PASS/FAIL (no RAM write, no count, verdict frozen).
REQ-025 SHALL increment store_count on each accepted store in RUN, saturating at 16'hFFFF.
REQ-026 SHALL drive ReadData = RAM word for aligned in-range DataAdr, else 32'h0; no read latency.

Reset
REQ-027 SHALL, on reset assertion, immediately force state RUN, done=0, pass=0, fail_code=0, store_count=0, timeout counter=0, independent of clk.
REQ-028 SHALL not reset RAM contents; reset mid-run clears verdict and counters only.
REQ-029 SHALL not accept a store on the edge where reset is high.

Structure
REQ-030 SHALL place state enum, fail_code encodings and default address constants in package xrisc_mbox_pkg.
REQ-031 SHALL instantiate one sub-module xrisc_dmem_ram (sync write, async read, DEPTH_WORDS parameter).

Verification
REQ-032 SHALL test: stores 7 to 96 then 25 to 100 -> RAM[24]=7, store_count=2, done=1 pass=1 cycle after second store.
REQ-033 SHALL test: store 24 to 100 -> done=1, pass=0, fail_code=1, ReadData at 100 = 24.
REQ-034 SHALL test: store to 102 (misaligned) and separately to 4096 -> fail_code=2, store_count=0, RAM unchanged.
REQ-035 SHALL test: no stores for TIMEOUT_CYCLES cycles -> fail_code=3 exactly at cycle TIMEOUT_CYCLES; store 25 to 100 afterwards ignored.
REQ-036 SHALL test: reset asserted mid-run between clock edges -> outputs zero immediately, prior RAM[24] still readable, new run reaches PASS.
